// File: rtl/pwm_capture.sv
// Servo PWM capture: high width and rise-to-rise period in clk cycles, classified to IDLE/DELIVERY/TOP.
// Result strobes 3+FILT_LEN cycles after the closing pwm_in rise; no backpressure, outputs hold between strobes.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int CNT_W        = 26,
  parameter int FILT_LEN     = 4,
  parameter int MAX_HIGH     = 100_000,
  parameter int TIMEOUT      = 1_080_000,
  parameter int IDLE_CNT     = 22_499,
  parameter int DELIVERY_CNT = 62_499,
  parameter int TOP_CNT      = 67_499,
  parameter int TOL          = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] pulse_width,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic [2:0]       position,
  output logic             signal_lost
);

  localparam logic [3:0]       FILT_LAST  = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_C   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [CNT_W:0]   TOL_C      = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {SEEK_LOW, ARMED, HIGH, LOW} state_t;

  logic [1:0]       sync_q;
  logic             filt;
  logic             filt_q;
  logic [3:0]       filt_cnt;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt;
  logic [CNT_W-1:0] per_cnt, per_nxt;
  logic [CNT_W-1:0] width_lat, width_nxt;
  logic [CNT_W-1:0] hi_inc, per_inc;
  logic             rise, fall, quiet;
  logic             publish, lose;

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

  function automatic logic [2:0] classify(input logic [CNT_W-1:0] w);
    if      (abs_diff(w, CNT_W'(IDLE_CNT))     <= TOL_C) return 3'b001;
    else if (abs_diff(w, CNT_W'(DELIVERY_CNT)) <= TOL_C) return 3'b010;
    else if (abs_diff(w, CNT_W'(TOP_CNT))      <= TOL_C) return 3'b011;
    else                                                 return 3'b000;
  endfunction

  // Filtered level follows the synchronized input only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      filt     <= 1'b0;
      filt_q   <= 1'b0;
      filt_cnt <= 4'd0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
      filt_q <= filt;
      if (sync_q[1] == filt) begin
        filt_cnt <= 4'd0;
      end else if (filt_cnt == FILT_LAST) begin
        filt     <= sync_q[1];
        filt_cnt <= 4'd0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  assign rise    = filt & ~filt_q;
  assign fall    = ~filt & filt_q;
  // Low must be seen through the whole conditioning pipeline, so a still-high input right after reset is not armed on.
  assign quiet   = ~filt & ~sync_q[1] & ~sync_q[0];
  assign hi_inc  = (&hi_cnt)  ? hi_cnt  : hi_cnt + ONE_C;
  assign per_inc = (&per_cnt) ? per_cnt : per_cnt + ONE_C;

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_cnt;
    per_nxt   = per_cnt;
    width_nxt = width_lat;
    publish   = 1'b0;
    lose      = 1'b0;
    case (state)
      SEEK_LOW: begin
        if (!quiet) begin
          per_nxt = '0;
        end else if (per_cnt >= SETTLE_C) begin
          state_nxt = ARMED;
          per_nxt   = ONE_C;
        end else begin
          per_nxt = per_inc;
        end
      end
      ARMED: begin
        if (rise) begin
          state_nxt = HIGH;
          hi_nxt    = ONE_C;
          per_nxt   = ONE_C;
        end else if (per_cnt >= TIMEOUT_C) begin
          lose    = 1'b1;
          per_nxt = ONE_C;
        end else begin
          per_nxt = per_inc;
        end
      end
      HIGH: begin
        if (fall) begin
          state_nxt = LOW;
          width_nxt = hi_cnt;
          per_nxt   = per_inc;
        end else if (hi_cnt >= MAX_HIGH_C) begin
          state_nxt = SEEK_LOW;
          lose      = 1'b1;
          per_nxt   = '0;
        end else begin
          hi_nxt  = hi_inc;
          per_nxt = per_inc;
        end
      end
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
          publish   = 1'b1;
          hi_nxt    = ONE_C;
          per_nxt   = ONE_C;
        end else if (per_cnt >= TIMEOUT_C) begin
          state_nxt = ARMED;
          lose      = 1'b1;
          per_nxt   = ONE_C;
        end else begin
          per_nxt = per_inc;
        end
      end
      default: state_nxt = SEEK_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SEEK_LOW;
      hi_cnt    <= '0;
      per_cnt   <= '0;
      width_lat <= '0;
    end else begin
      state     <= state_nxt;
      hi_cnt    <= hi_nxt;
      per_cnt   <= per_nxt;
      width_lat <= width_nxt;
    end
  end

  // per_cnt still holds the closing period here; it is restarted in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_width <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      position    <= 3'b000;
      signal_lost <= 1'b1;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        pulse_width <= width_lat;
        period      <= per_cnt;
        position    <= classify(width_lat);
        signal_lost <= 1'b0;
      end else if (lose) begin
        signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboarded bench for pwm_capture with scaled-down timing parameters.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W    = 16;
  localparam int FILT_LEN = 4;
  localparam int LAT      = FILT_LEN + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] pulse_width;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic [2:0]       position;
  logic             signal_lost;

  pwm_capture #(
    .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .MAX_HIGH(1000), .TIMEOUT(3000),
    .IDLE_CNT(200), .DELIVERY_CNT(500), .TOP_CNT(560), .TOL(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .pulse_width(pulse_width), .period(period), .meas_valid(meas_valid),
    .position(position), .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int w; int p; int pos;} exp_t;
  exp_t q[$];
  exp_t prev;
  exp_t mon_e;
  bit   prev_ok = 1'b0;
  int   last_rise = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_period();
    if (prev_ok) q.push_back(prev);
    last_rise = cyc;
    pwm_in = 1'b1;
  endtask

  task automatic pulse(input int w, input int p, input int pos);
    begin_period();
    wait_cyc(w);
    pwm_in = 1'b0;
    wait_cyc(p - w);
    prev = '{w, p, pos};
    prev_ok = 1'b1;
  endtask

  // Pulse with a short high glitch of g cycles placed goff cycles after the fall.
  task automatic pulse_g(input int w, input int p, input int pos, input int goff, input int g);
    begin_period();
    wait_cyc(w);
    pwm_in = 1'b0;
    wait_cyc(goff);
    pwm_in = 1'b1;
    wait_cyc(g);
    pwm_in = 1'b0;
    wait_cyc(p - w - goff - g);
    prev = '{w, p, pos};
    prev_ok = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_width"}, pulse_width, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_position"}, position, 0);
    chk({tag, "_valid"}, meas_valid, 0);
    chk({tag, "_lost"}, signal_lost, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && meas_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got width=%0d period=%0d required no strobe (cycle %0d)",
                 pulse_width, period, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("strobe_width", pulse_width, mon_e.w);
        chk("strobe_period", period, mon_e.p);
        chk("strobe_position", position, mon_e.pos);
        chk("strobe_lost", signal_lost, 0);
        chk("strobe_latency", cyc - last_rise, LAT);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with pwm_in already high, then released while still high.
    rst_n  = 1'b0;
    pwm_in = 1'b1;
    wait_cyc(3);
    chk_reset_state("reset");
    rst_n = 1'b1;
    wait_cyc(300);
    chk("release_high_lost", signal_lost, 1);
    pwm_in = 1'b0;
    wait_cyc(300);
    chk("release_low_lost", signal_lost, 1);

    // Nominal IDLE, three periods.
    pulse(200, 1500, 1);
    pulse(200, 1500, 1);
    pulse(200, 1500, 1);
    chk("idle_hold_width", pulse_width, 200);
    chk("idle_hold_period", period, 1500);
    chk("idle_hold_lost", signal_lost, 0);

    // Classification including the inclusive tolerance edges.
    pulse(500, 1200, 2);
    pulse(560, 1200, 3);
    pulse(520, 1200, 2);
    pulse(521, 1200, 0);
    pulse(180, 1200, 1);
    pulse(179, 1200, 0);
    pulse(580, 1200, 3);
    pulse(581, 1200, 0);

    // Glitches in the low phase: 2 and 3 cycles are filtered, 4 cycles splits the period.
    pulse_g(200, 1500, 1, 300, 2);
    pulse_g(200, 1500, 1, 300, 3);
    pulse(200, 500, 1);
    pulse(4, 1000, 0);
    pulse(200, 1500, 1);

    // Stuck high past the high-time limit, then resume.
    begin_period();
    wait_cyc(900);
    chk("stuck_lost_early", signal_lost, 0);
    wait_cyc(200);
    chk("stuck_lost", signal_lost, 1);
    chk("stuck_position", position, 1);
    chk("stuck_width", pulse_width, 200);
    wait_cyc(400);
    pwm_in = 1'b0;
    wait_cyc(500);
    prev_ok = 1'b0;
    pulse(200, 1500, 1);
    chk("resume_lost", signal_lost, 1);
    pulse(500, 1500, 2);
    pulse(200, 1500, 1);

    // One-cycle reset in the middle of a high pulse.
    begin_period();
    wait_cyc(50);
    rst_n = 1'b0;
    wait_cyc(1);
    chk_reset_state("midreset");
    rst_n = 1'b1;
    wait_cyc(449);
    pwm_in = 1'b0;
    wait_cyc(1000);
    prev_ok = 1'b0;
    pulse(560, 1500, 3);
    chk("midreset_first_lost", signal_lost, 1);
    pulse(200, 1500, 1);

    // Constant low: period timeout, no strobe, outputs retained.
    wait_cyc(3500);
    prev_ok = 1'b0;
    chk("timeout_lost", signal_lost, 1);
    chk("timeout_width", pulse_width, 560);
    chk("timeout_position", position, 3);
    wait_cyc(20);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
